// File: rtl/ss_sequencer_pkg.sv
// Shared mapper save-state definitions: slot/data widths and the
// sequencer state encoding.
package ss_sequencer_pkg;

    localparam int SS_SLOT_W    = 8;
    localparam int SS_DATA_W    = 8;
    localparam int SS_MAX_SLOTS = 1 << SS_SLOT_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_NEXT,
        ST_DONE
    } ss_state_e;

endpackage

// File: rtl/ss_slot_timer.sv
// Per-phase cycle down-counter for the save-state sequencer; reports
// expiry on the final cycle of the loaded phase length.
module ss_slot_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ss_sequencer.sv
// Save-state sequencer: walks every mapper slot, copying mapper registers
// into the buffer (save) or buffer contents back into the mapper (load).
module ss_sequencer
    import ss_sequencer_pkg::*;
#(
    parameter int NUM_SLOTS = 128,
    parameter int SETUP_CYC = 2,
    parameter int STRB_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 dir,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 ss_act,
    output logic                 ss_we,
    output logic [SS_SLOT_W-1:0] ss_addr,
    output logic [SS_DATA_W-1:0] ss_wdat,
    input  logic [SS_DATA_W-1:0] ss_rdat,
    output logic [SS_SLOT_W-1:0] mem_addr,
    output logic                 mem_we,
    output logic [SS_DATA_W-1:0] mem_wdat,
    input  logic [SS_DATA_W-1:0] mem_rdat
);

    if (NUM_SLOTS < 1 || NUM_SLOTS > SS_MAX_SLOTS) begin : g_bad_num_slots
        $error("ss_sequencer: NUM_SLOTS must be in 1..%0d", SS_MAX_SLOTS);
    end
    if (SETUP_CYC < 2 || SETUP_CYC > SS_MAX_SLOTS) begin : g_bad_setup_cyc
        $error("ss_sequencer: SETUP_CYC must be in 2..%0d", SS_MAX_SLOTS);
    end
    if (STRB_CYC < 1 || STRB_CYC > SS_MAX_SLOTS) begin : g_bad_strb_cyc
        $error("ss_sequencer: STRB_CYC must be in 1..%0d", SS_MAX_SLOTS);
    end

    localparam logic [SS_SLOT_W-1:0] LAST_SLOT  = SS_SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SS_SLOT_W-1:0] SETUP_LOAD = SS_SLOT_W'(SETUP_CYC - 1);
    localparam logic [SS_SLOT_W-1:0] STRB_LOAD  = SS_SLOT_W'(STRB_CYC - 1);

    ss_state_e              state_q, state_d;
    logic                   dir_q;
    logic [SS_SLOT_W-1:0]   slot_q;
    logic                   accept, slot_inc, capture;
    logic                   tmr_load, tmr_expired;
    logic [SS_SLOT_W-1:0]   tmr_val;

    ss_slot_timer #(
        .CNT_W (SS_SLOT_W)
    ) u_slot_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        slot_inc = 1'b0;
        capture  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Last setup cycle: mem_rdat/ss_rdat are settled for this slot.
                if (tmr_expired) begin
                    capture  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = dir_q ? STRB_LOAD : '0;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_expired) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Abort is only honoured here, so a started strobe always finishes.
                if (slot_q == LAST_SLOT || abort) begin
                    state_d = ST_DONE;
                end else begin
                    slot_inc = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                    state_d  = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            slot_q   <= '0;
            ss_wdat  <= '0;
            mem_wdat <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dir_q  <= dir;
                slot_q <= '0;
            end else if (slot_inc) begin
                slot_q <= slot_q + SS_SLOT_W'(1);
            end
            if (capture) begin
                if (dir_q) begin
                    ss_wdat <= mem_rdat;
                end else begin
                    mem_wdat <= ss_rdat;
                end
            end
        end
    end

    // Decoded from the state register so reset clears them immediately.
    assign busy     = (state_q inside {ST_SETUP, ST_STROBE, ST_NEXT});
    assign ss_act   = busy;
    assign done     = (state_q == ST_DONE);
    assign err      = start && (state_q != ST_IDLE);
    assign ss_we    = (state_q == ST_STROBE) && dir_q;
    assign mem_we   = (state_q == ST_STROBE) && !dir_q;
    assign ss_addr  = slot_q;
    assign mem_addr = slot_q;

endmodule

// File: tb/tb_ss_sequencer.sv
// Self-checking bench for ss_sequencer: mapper register file and buffer RAM
// models plus a slot-level reference model of each save/load operation.
module tb_ss_sequencer;

    localparam int NUM_SLOTS = 128;
    localparam int SETUP_CYC = 2;
    localparam int STRB_CYC  = 2;
    localparam int MAX_CYC   = 2000;

    localparam logic [1:0] PRE_NONE   = 2'd0;
    localparam logic [1:0] PRE_RANDOM = 2'd1;
    localparam logic [1:0] PRE_MAP_A0 = 2'd2;
    localparam logic [1:0] PRE_BUF_5A = 2'd3;

    typedef struct packed {
        logic       d;
        int         abort_slot;
        logic       on_strobe;
        logic       with_start;
        int         restart_at;
        int         exp_cycles;
        logic [1:0] preset;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, err, ss_act, ss_we, mem_we;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, mem_addr, mem_wdat, mem_rdat;

    logic [7:0] map_regs  [256];
    logic [7:0] buf_mem   [256];
    logic [7:0] map_stage [256];
    logic [7:0] buf_stage [256];
    logic       stage_req = 1'b0;

    logic [7:0] exp_map [256];
    logic [7:0] exp_buf [256];
    logic [7:0] orig_map [256];

    int n_vec = 0;
    int n_err = 0;

    ss_sequencer #(
        .NUM_SLOTS (NUM_SLOTS),
        .SETUP_CYC (SETUP_CYC),
        .STRB_CYC  (STRB_CYC)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dir      (dir),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ss_wdat  (ss_wdat),
        .ss_rdat  (ss_rdat),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdat (mem_wdat),
        .mem_rdat (mem_rdat)
    );

    always #5 clk = ~clk;

    // Mapper: combinational readback. Buffer: synchronous read, one-cycle latency.
    assign ss_rdat = map_regs[ss_addr];

    always @(posedge clk) begin
        if (stage_req) begin
            for (int i = 0; i < 256; i++) begin
                map_regs[i] <= map_stage[i];
                buf_mem[i]  <= buf_stage[i];
            end
        end else begin
            if (ss_we)  map_regs[ss_addr] <= ss_wdat;
            if (mem_we) buf_mem[mem_addr] <= mem_wdat;
        end
        mem_rdat <= buf_mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic randomize_model();
        for (int i = 0; i < 256; i++) begin
            exp_map[i] = 8'($urandom);
            exp_buf[i] = 8'($urandom);
        end
    endtask

    task automatic stage_model();
        for (int i = 0; i < 256; i++) begin
            map_stage[i] = exp_map[i];
            buf_stage[i] = exp_buf[i];
        end
        @(negedge clk);
        stage_req = 1'b1;
        @(negedge clk);
        stage_req = 1'b0;
    endtask

    task automatic apply_preset(input logic [1:0] p);
        case (p)
            PRE_RANDOM: randomize_model();
            PRE_MAP_A0: for (int i = 0; i < 4; i++) exp_map[i] = 8'(8'hA0 + i);
            PRE_BUF_5A: for (int i = 0; i < 4; i++) exp_buf[i] = 8'(8'h5A + i);
            default: ;
        endcase
        stage_model();
    endtask

    task automatic compare_images(input string tag);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            check($sformatf("%s:map[%0d]", tag, i), 32'(map_regs[i]), 32'(exp_map[i]));
            check($sformatf("%s:buf[%0d]", tag, i), 32'(buf_mem[i]), 32'(exp_buf[i]));
        end
    endtask

    // One full operation; abort_slot < 0 means run to the last slot.
    task automatic run_op(input string tag, input logic d, input int abort_slot,
                          input logic on_strobe, input logic with_start,
                          input int restart_at, input int exp_cycles);
        int   n, cyc, done_cyc, bad, we_cyc, mwe_cyc, win_len, win_cnt, mwe_cnt;
        logic prev_we;
        logic [7:0] prev_addr;
        n = (abort_slot >= 0) ? abort_slot + 1 : NUM_SLOTS;
        cyc = 0; done_cyc = -1; bad = 0; we_cyc = 0; mwe_cyc = 0;
        win_len = 0; win_cnt = 0; mwe_cnt = 0; prev_we = 1'b0; prev_addr = '0;

        @(negedge clk);
        check({tag, ":idle_busy"}, 32'(busy), 32'd0);
        start = 1'b1;
        dir   = d;
        abort = with_start;
        #1;
        check({tag, ":start_err"}, 32'(err), 32'd0);

        while (cyc < MAX_CYC && done_cyc < 0) begin
            @(negedge clk);
            start = (restart_at > 0) && (cyc + 1 == restart_at);
            dir   = ~d;
            cyc++;
            #1;
            if (restart_at > 0 && cyc == restart_at)     check({tag, ":err_pulse"}, 32'(err), 32'd1);
            if (restart_at > 0 && cyc == restart_at + 1) check({tag, ":err_clear"}, 32'(err), 32'd0);
            if (cyc == 1) begin
                check({tag, ":busy_rise"}, 32'(busy), 32'd1);
                check({tag, ":act_rise"}, 32'(ss_act), 32'd1);
            end
            if (done) begin
                done_cyc = cyc;
                check({tag, ":busy_at_done"}, 32'(busy), 32'd0);
                check({tag, ":act_at_done"}, 32'(ss_act), 32'd0);
            end else if (!busy) begin
                bad++;
            end
            if (ss_we && mem_we) bad++;
            if (!d && ss_we) bad++;
            if (d && mem_we) bad++;
            if (mem_addr != ss_addr) bad++;
            if (busy != ss_act) bad++;
            if (ss_we) begin
                we_cyc++;
                if (!prev_we) begin
                    win_len = 0;
                    if (int'(ss_addr) != win_cnt) bad++;
                    win_cnt++;
                end else if (ss_addr != prev_addr) begin
                    bad++;
                end
                win_len++;
                if (ss_wdat != exp_buf[ss_addr]) bad++;
            end else if (prev_we && win_len != STRB_CYC) begin
                bad++;
            end
            if (mem_we) begin
                mwe_cyc++;
                if (int'(mem_addr) != mwe_cnt) bad++;
                mwe_cnt++;
                if (mem_wdat != exp_map[mem_addr]) bad++;
            end
            prev_we   = ss_we;
            prev_addr = ss_addr;
            if (abort_slot >= 0 && !with_start && busy && int'(ss_addr) == abort_slot &&
                (!on_strobe || ss_we || mem_we))
                abort = 1'b1;
        end
        abort = 1'b0;

        check({tag, ":done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({tag, ":done_cycle"}, done_cyc, exp_cycles);
        @(negedge clk);
        #1;
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":busy_after"}, 32'(busy), 32'd0);
        check({tag, ":invariants"}, bad, 0);
        check({tag, ":ss_we_cycles"}, we_cyc, d ? n * STRB_CYC : 0);
        check({tag, ":mem_we_cycles"}, mwe_cyc, d ? 0 : n);

        for (int i = 0; i < n; i++) begin
            if (d) exp_map[i] = exp_buf[i];
            else   exp_buf[i] = exp_map[i];
        end
        compare_images(tag);
    endtask

    vec_t vecs [7];

    initial begin
        #1;
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:err", 32'(err), 32'd0);
        check("reset:ss_act", 32'(ss_act), 32'd0);
        check("reset:ss_we", 32'(ss_we), 32'd0);
        check("reset:mem_we", 32'(mem_we), 32'd0);
        check("reset:ss_addr", 32'(ss_addr), 32'd0);
        check("reset:ss_wdat", 32'(ss_wdat), 32'd0);
        check("reset:mem_wdat", 32'(mem_wdat), 32'd0);

        randomize_model();
        stage_model();
        @(negedge clk);
        rst_n = 1'b1;

        //                 d     abort on_str w_start restart cycles preset
        vecs[0] = '{1'b0,   3, 1'b0, 1'b0,  -1,  17, PRE_MAP_A0};
        vecs[1] = '{1'b1,   3, 1'b0, 1'b0,  -1,  21, PRE_BUF_5A};
        vecs[2] = '{1'b0,   0, 1'b0, 1'b1,  -1,   5, PRE_RANDOM};
        vecs[3] = '{1'b1,   0, 1'b0, 1'b1,  -1,   6, PRE_NONE};
        vecs[4] = '{1'b1,   2, 1'b1, 1'b0,  -1,  16, PRE_RANDOM};
        vecs[5] = '{1'b0,  -1, 1'b0, 1'b0,   5, 513, PRE_RANDOM};
        vecs[6] = '{1'b1,  -1, 1'b0, 1'b0,  -1, 641, PRE_RANDOM};

        for (int v = 0; v < 7; v++) begin
            apply_preset(vecs[v].preset);
            run_op($sformatf("vec%0d", v), vecs[v].d, vecs[v].abort_slot, vecs[v].on_strobe,
                   vecs[v].with_start, vecs[v].restart_at, vecs[v].exp_cycles);
        end

        // Reset in the middle of a load strobe.
        begin
            int waited, bad;
            waited = 0; bad = 0;
            apply_preset(PRE_RANDOM);
            @(negedge clk);
            start = 1'b1; dir = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            while (!ss_we && waited < 50) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("rst_mid:we_seen", 32'(ss_we), 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_mid:ss_we", 32'(ss_we), 32'd0);
            check("rst_mid:busy", 32'(busy), 32'd0);
            check("rst_mid:ss_act", 32'(ss_act), 32'd0);
            check("rst_mid:ss_addr", 32'(ss_addr), 32'd0);
            check("rst_mid:ss_wdat", 32'(ss_wdat), 32'd0);
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (c == 3) rst_n = 1'b1;
                #1;
                if (done || ss_we || mem_we || busy) bad++;
            end
            check("rst_mid:quiet_after", bad, 0);
            stage_model();
        end

        // Save then load round trip over every slot.
        randomize_model();
        stage_model();
        run_op("rt_save", 1'b0, -1, 1'b0, 1'b0, -1, NUM_SLOTS * (SETUP_CYC + 2) + 1);
        for (int i = 0; i < 256; i++) orig_map[i] = exp_map[i];
        for (int i = 0; i < 256; i++) exp_map[i] = 8'($urandom);
        stage_model();
        run_op("rt_load", 1'b1, -1, 1'b0, 1'b0, -1, NUM_SLOTS * (SETUP_CYC + STRB_CYC + 1) + 1);
        for (int i = 0; i < NUM_SLOTS; i++)
            check($sformatf("roundtrip[%0d]", i), 32'(map_regs[i]), 32'(orig_map[i]));

        // Random operations against the slot-level model.
        for (int r = 0; r < 6; r++) begin
            logic d;
            int   mode, slot, n, per;
            d    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            slot = (mode == 0) ? -1 : (mode == 3) ? 0 : $urandom_range(0, NUM_SLOTS - 1);
            n    = (slot < 0) ? NUM_SLOTS : slot + 1;
            per  = d ? SETUP_CYC + STRB_CYC + 1 : SETUP_CYC + 2;
            apply_preset(PRE_RANDOM);
            run_op($sformatf("rand%0d", r), d, slot, 1'(mode == 2), 1'(mode == 3), -1, n * per + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ss_sequencer.md
SS_SEQUENCER -- requirements
Module: ss_sequencer

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 128, giving the number of save-state slots, ss_addr 0..NUM_SLOTS-1.
REQ-002 SHALL have parameter SETUP_CYC, default 2, giving the clk cycles ss_addr/ss_wdat are stable before the strobe.
REQ-003 SHALL have parameter STRB_CYC, default 2, giving the clk cycles ss_we is held high per load slot.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle command pulse.
REQ-007 dir  in  1  sampled with start; 0 = save (mapper->buffer), 1 = load (buffer->mapper).
REQ-008 abort  in  1  level; ends the operation at the next slot boundary.
REQ-009 busy  out  1  high from the accepted start until the done pulse.
REQ-010 done  out  1  one-cycle pulse at the end of the operation.
REQ-011 err  out  1  one-cycle pulse when start arrives while busy.
REQ-012 ss_act  out  1  save-state mode to the mapper; high while busy.
REQ-013 ss_we  out  1  mapper register write strobe (load only).
REQ-014 ss_addr  out  8  mapper slot index.
REQ-015 ss_wdat  out  8  data to the mapper (on its cpu_dat path).
REQ-016 ss_rdat  in  8  mapper readback, combinational from ss_addr.
REQ-017 mem_addr  out  8  buffer address, always equal to ss_addr.
REQ-018 mem_we  out  1  buffer write (save only).
REQ-019 mem_wdat  out  8  buffer write data.
REQ-020 mem_rdat  in  8  buffer read data, valid one cycle after mem_addr.

Function
REQ-021 States SHALL be IDLE, SETUP, STROBE, NEXT, DONE.
REQ-022 IDLE: on start, latch dir, set slot=0, go to SETUP, and assert busy/ss_act on the next cycle.
REQ-023 SETUP: hold slot for SETUP_CYC cycles (minimum 2, to cover mem_rdat latency), then go to STROBE.
REQ-024 Save STROBE: one cycle; mem_we=1 and mem_wdat=ss_rdat sampled that cycle; then go to NEXT.
REQ-025 Load: ss_wdat SHALL be registered from mem_rdat at the last SETUP cycle and held through STROBE; ss_we=1 for STRB_CYC cycles; then go to NEXT.
REQ-026 NEXT: if slot==NUM_SLOTS-1 or abort, go to DONE; else slot+1 and go to SETUP.
REQ-027 DONE: done=1 for one cycle; busy and ss_act drop in the same cycle; then go to IDLE.
REQ-028 The slot counter is 8 bits and SHALL never wrap; NUM_SLOTS>256 is illegal (elaboration error).
REQ-029 ss_we and mem_we SHALL never be high in the same cycle; ss_we SHALL be 0 in save mode; mem_we SHALL be 0 in load mode.
REQ-030 ss_addr SHALL change only in NEXT, never while ss_we=1.
REQ-031 An abort asserted mid-STROBE SHALL let that slot complete; no partial strobe.
REQ-032 start while busy: ignored, err pulse, operation unaffected.
REQ-033 start and abort in the same IDLE cycle: start accepted; abort is evaluated at the first NEXT, so exactly one slot is transferred.
REQ-034 Total cycles for a save: NUM_SLOTS*(SETUP_CYC+2)+1 from start to done.
REQ-035 Total cycles for a load: NUM_SLOTS*(SETUP_CYC+STRB_CYC+1)+1 from start to done.

Reset
REQ-036 rst_n low SHALL force IDLE and set busy, done, err, ss_act, ss_we, mem_we=0 and ss_addr, ss_wdat, mem_wdat=0, asynchronously.
REQ-037 Reset during an operation SHALL abort immediately, with no done pulse and no further ss_we/mem_we.

Structure
REQ-038 The state encoding and the shared save-state width constant (8-bit slot, 8-bit data) SHALL live in the shared mapper defs package.
REQ-039 One sub-module, ss_slot_timer, SHALL provide the SETUP/STROBE cycle down-counter; everything else stays flat.

Verification
REQ-040 Save, NUM_SLOTS=4, SETUP_CYC=2, mapper model returns 8'hA0+addr -> buffer holds A0,A1,A2,A3; done at cycle 17.
REQ-041 Load, buffer 5A,5B,5C,5D -> four ss_we windows of 2 cycles at ss_addr 0..3 with ss_wdat 5A..5D; done at cycle 21.
REQ-042 Save then load round-trip, NUM_SLOTS=128, against the map_012-style register model -> all 128 slots read back identical.
REQ-043 Start a save, start again at cycle 5 -> err pulse at cycle 5; original operation completes normally.
REQ-044 Abort raised during the slot-2 STROBE in a load -> slot 2 write completes, done follows, slot 3 is never written.
REQ-045 rst_n low during a load STROBE -> ss_we, busy, ss_act drop asynchronously; no done pulse.
